// File: rtl/comb_y1_if.sv
// comb_y1_if: function inputs A/B/C and registered Y status outputs of comb_y1
interface comb_y1_if #(parameter int COUNT_W = 8);
    logic A, B, C;
    logic Y, y_rise, y_fall;
    logic [COUNT_W-1:0] y_count;
    modport master(output A, B, C, input Y, y_rise, y_fall, y_count);
    modport slave(input A, B, C, output Y, y_rise, y_fall, y_count);
endinterface

// File: rtl/comb_y1.sv
// comb_y1: registered 3-input truth-table unit with edge pulses and saturating high-count
module comb_y1 #(
    parameter logic [7:0] TT      = 8'b1110_1000,
    parameter int         COUNT_W = 8
) (
    input logic   clk,
    input logic   rst_n,
    comb_y1_if.slave bus
);
    logic y_next;
    // look up the next output in the truth table, A is the index MSB
    always_comb y_next = TT[{bus.A, bus.B, bus.C}];
    // register Y, its edge pulses and the saturating count of high cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.Y       <= 1'b0;
            bus.y_rise  <= 1'b0;
            bus.y_fall  <= 1'b0;
            bus.y_count <= '0;
        end else begin
            bus.Y      <= y_next;
            bus.y_rise <= y_next & ~bus.Y;
            bus.y_fall <= ~y_next & bus.Y;
            if (y_next && !(&bus.y_count)) bus.y_count <= bus.y_count + COUNT_W'(1);
        end
    end
endmodule

// File: tb/tb_comb_y1.sv
// tb_comb_y1: scoreboard bench for comb_y1 (majority and NOR3 instances)
module tb_comb_y1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    comb_y1_if #(.COUNT_W(8)) maj_if();
    comb_y1_if #(.COUNT_W(8)) nor_if();

    comb_y1 #(.TT(8'b1110_1000), .COUNT_W(8)) dut_maj(.clk(clk), .rst_n(rst_n), .bus(maj_if));
    comb_y1 #(.TT(8'b0000_0001), .COUNT_W(8)) dut_nor(.clk(clk), .rst_n(rst_n), .bus(nor_if));

    typedef struct {
        logic y, rise, fall;
        int   cnt;
        logic ny;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   m_y = 1'b0;
    int   m_cnt = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", n, act, exp, $time);
        end
    endtask

    // drive one clock of stimulus and push what both instances must show after the edge
    task automatic step(input bit r, input logic [2:0] abc);
        exp_t e;
        bit yn;
        @(negedge clk);
        rst_n = r;
        {maj_if.A, maj_if.B, maj_if.C} = abc;
        {nor_if.A, nor_if.B, nor_if.C} = abc;
        if (!r) begin
            e = '{1'b0, 1'b0, 1'b0, 0, 1'b0};
            m_y = 1'b0;
            m_cnt = 0;
        end else begin
            yn = $countones(abc) >= 2;
            e.rise = yn && !m_y;
            e.fall = !yn && m_y;
            e.y = yn;
            m_cnt = (yn && m_cnt < 255) ? m_cnt + 1 : m_cnt;
            e.cnt = m_cnt;
            e.ny = (abc == 3'b000);
            m_y = yn;
        end
        sb.push_back(e);
    endtask

    // monitor: outputs are presented every edge; compare just after it
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("Y", 32'(maj_if.Y), 32'(e.y));
            chk("y_rise", 32'(maj_if.y_rise), 32'(e.rise));
            chk("y_fall", 32'(maj_if.y_fall), 32'(e.fall));
            chk("y_count", 32'(maj_if.y_count), 32'(e.cnt));
            chk("nor_Y", 32'(nor_if.Y), 32'(e.ny));
        end
    end

    logic [2:0] seq [8] = '{3'b000, 3'b100, 3'b011, 3'b101, 3'b110, 3'b001, 3'b111, 3'b010};

    initial begin
        maj_if.A = 1'b1; maj_if.B = 1'b1; maj_if.C = 1'b1;
        nor_if.A = 1'b1; nor_if.B = 1'b1; nor_if.C = 1'b1;
        repeat (2) step(1'b0, 3'b111);
        for (int i = 0; i < 8; i++) step(1'b1, seq[i]);
        repeat (300) step(1'b1, 3'b111);
        step(1'b0, 3'b000);
        repeat (37) step(1'b1, 3'b111);
        step(1'b0, 3'b111);
        repeat (3) step(1'b1, 3'b111);
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i));
        for (int i = 0; i < 400; i++) step($urandom_range(0, 15) != 0, 3'($urandom_range(0, 7)));
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
